rv_imem_responder: RTL and testbench
====================================

RV_IMEM_RESPONDER -- requirements
Module: rv_imem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte-address width of fetch requests.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit instruction words stored.
REQ-003 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-004 SHALL have port clk  input  1  clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  1  fetch request valid.
REQ-007 SHALL have port req_ready_o  output  1  fetch request accepted this cycle when high with req_valid_i.
REQ-008 SHALL have port req_addr_i  input  ADDR_WIDTH  fetch byte address.
REQ-009 SHALL have port resp_valid_o  output  1  response valid.
REQ-010 SHALL have port resp_ready_i  input  1  consumer accepts response.
REQ-011 SHALL have port resp_instr_o  output  32  fetched instruction.
REQ-012 SHALL have port resp_err_o  output  2  00 ok, 01 misaligned, 10 out of range.
REQ-013 SHALL have port flush_i  input  1  discard all in-flight and buffered responses (taken branch/jump).
REQ-014 SHALL have ports prog_we_i (input 1), prog_addr_i (input DEPTH_LOG2, word index), prog_data_i (input 32) for program preload.
REQ-015 SHALL have port busy_o  output  1  high when any request is in flight or buffered.

Function
REQ-016 SHALL accept a request on the cycle req_valid_i and req_ready_o are both high.
REQ-017 SHALL read storage synchronously; earliest resp_valid_o is the cycle after acceptance (1-cycle latency).
REQ-018 SHALL return responses in acceptance order, including error responses.
REQ-019 SHALL drive req_ready_o = (in-flight count + buffered count < 2) AND NOT flush_i AND NOT prog_we_i.
REQ-020 SHALL buffer up to 2 responses; with resp_ready_i low, accepted data is held stable and resp_valid_o stays high.
REQ-021 SHALL flag misaligned when req_addr_i[1:0] != 0; this takes priority over out-of-range.
REQ-022 SHALL flag out-of-range when req_addr_i < BASE_ADDR or (req_addr_i - BASE_ADDR) >= 4*2^DEPTH_LOG2, compared at full ADDR_WIDTH with no truncation or wrap.
REQ-023 SHALL return resp_instr_o = 32'h0000_0013 (NOP) for any errored response.
REQ-024 SHALL index storage with (req_addr_i - BASE_ADDR)[DEPTH_LOG2+1:2].
REQ-025 SHALL, when flush_i is high, clear the in-flight entry and both buffer entries at the next edge, so that resp_valid_o is 0 the following cycle; a response is still handshaken normally in the flush cycle itself.
REQ-026 SHALL write prog_data_i to the word at prog_addr_i on an edge with prog_we_i high.
REQ-027 SHALL give a same-cycle read and write to the same word read-first (the old data is returned).
REQ-028 SHALL permit a buffer push and pop in the same cycle without a loss of occupancy or throughput; sustained throughput is 1 response/cycle with resp_ready_i high.

Reset
REQ-029 SHALL on rst force resp_valid_o=0, busy_o=0, resp_err_o=0, resp_instr_o=0, and empty the in-flight and buffer state; rst SHALL override flush_i and the handshakes.
REQ-030 SHALL NOT reset storage contents; the program survives rst, and rst mid-operation drops only the pending responses.
REQ-031 SHALL drive req_ready_o=0 during the reset cycle.

Structure
REQ-032 SHALL take error codes ERR_OK/ERR_MISALIGN/ERR_RANGE and the NOP constant from the shared package rv_imem_pkg.
REQ-033 SHALL implement the 2-entry response buffer as the sub-module rv_resp_fifo (parameterized width, 34 bits here).
REQ-034 SHALL infer storage as a single synchronous-read array within rv_imem_responder.

Verification
REQ-035 Case: preload word 0=32'h00500093, word 1=32'h00A00113; request 0x0 then 0x4 back-to-back with resp_ready_i=1 -> responses at cycles +1 and +2, those instructions, err 00.
REQ-036 Case: request 0x6 -> response NOP, err 01; request BASE_ADDR+4*2^DEPTH_LOG2 -> NOP, err 10; request 0x2 beyond range -> err 01 (priority).
REQ-037 Case: resp_ready_i=0, issue 3 requests -> only 2 accepted, req_ready_o=0 after that, data stable; raise resp_ready_i -> both drain in order.
REQ-038 Case: 2 responses buffered, assert flush_i one cycle -> resp_valid_o=0 next cycle, busy_o=0; a new request after the flush returns the correct data.
REQ-039 Case: prog_we_i writes word 3=32'hDEADBEEF while a read of 0xC is in flight -> the old value is returned; a re-read returns 32'hDEADBEEF.
REQ-040 Case: rst asserted with 2 responses buffered -> resp_valid_o=0 next cycle; storage contents unchanged after reset.

Source files
------------

// File: rtl/rv_imem_pkg.sv
// rtl/rv_imem_pkg.sv - shared error codes, NOP constant and response record for the instruction memory responder
package rv_imem_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } err_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    err_e        err;
    logic [31:0] instr;
  } resp_t;

  localparam int unsigned RESP_W = $bits(resp_t);

  // Errored fetches always carry a NOP so a speculative consumer executes nothing harmful
  function automatic resp_t make_resp(input err_e err, input logic [31:0] data);
    resp_t r;
    r.err   = err;
    r.instr = (err == ERR_OK) ? data : NOP_INSTR;
    return r;
  endfunction

endpackage

// File: rtl/rv_resp_fifo.sv
// rtl/rv_resp_fifo.sv - two-entry response buffer with flush and same-cycle push/pop
module rv_resp_fifo #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  input  logic             m_tready,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic [WIDTH-1:0] slot_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  always_comb begin
    m_tvalid = (count_q != 2'd0);
    m_tdata  = slot_q[rd_ptr_q];
    count_o  = count_q;
    pop      = m_tvalid && m_tready;
    push     = s_tvalid && ((count_q != 2'd2) || pop);

    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + 2'(push) - 2'(pop);

    if (push) begin
      slot_d[wr_ptr_q] = s_tdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    slot_q <= slot_d;
  end

endmodule

// File: rtl/rv_imem_responder.sv
// rtl/rv_imem_responder.sv - instruction fetch responder: sync-read program store, 1-cycle latency, 2-deep response buffer
module rv_imem_responder
  import rv_imem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_instr_o,
  output logic [1:0]            resp_err_o,
  input  logic                  flush_i,
  input  logic                  prog_we_i,
  input  logic [DEPTH_LOG2-1:0] prog_addr_i,
  input  logic [31:0]           prog_data_i,
  output logic                  busy_o
);

  localparam int unsigned         WORDS = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH + 1)'(4) << DEPTH_LOG2;

  logic [31:0]           mem [WORDS];
  logic [31:0]           rd_data_q;
  logic                  infl_valid_q, infl_valid_d;
  err_e                  infl_err_q, infl_err_d;

  logic [ADDR_WIDTH:0]   offset;
  logic                  misalign, out_of_range;
  err_e                  req_err;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [1:0]            occupancy;
  logic                  accept;
  logic                  bypass;
  resp_t                 infl_resp, head;

  logic                  fifo_push, fifo_out_valid, fifo_pop;
  logic [RESP_W-1:0]     fifo_out;
  logic [1:0]            fifo_count;

  always_comb begin
    // One extra bit keeps the offset compare honest near the top of the address space
    offset       = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
    misalign     = (req_addr_i[1:0] != 2'b00);
    out_of_range = (req_addr_i < BASE_ADDR) || (offset >= SPAN);
    req_err      = misalign ? ERR_MISALIGN : (out_of_range ? ERR_RANGE : ERR_OK);
    rd_idx       = offset[DEPTH_LOG2+1:2];

    occupancy    = fifo_count + 2'(infl_valid_q);
    req_ready_o  = !rst && (occupancy < 2'd2) && !flush_i && !prog_we_i;
    accept       = req_valid_i && req_ready_o;

    infl_resp    = make_resp(infl_err_q, rd_data_q);
    resp_valid_o = fifo_out_valid || infl_valid_q;
    head         = fifo_out_valid ? resp_t'(fifo_out) : infl_resp;
    if (!resp_valid_o) begin
      head = '0;
    end
    resp_instr_o = head.instr;
    resp_err_o   = head.err;

    // The in-flight word goes straight out only when nothing older is buffered
    bypass       = !fifo_out_valid && infl_valid_q && resp_ready_i;
    fifo_pop     = resp_ready_i;
    fifo_push    = infl_valid_q && !bypass;

    infl_valid_d = accept;
    infl_err_d   = accept ? req_err : infl_err_q;

    busy_o       = infl_valid_q || (fifo_count != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_valid_q <= 1'b0;
      infl_err_q   <= ERR_OK;
    end else begin
      infl_valid_q <= infl_valid_d;
      infl_err_q   <= infl_err_d;
    end
  end

  // Program store is never reset; read-before-write falls out of the non-blocking update
  always_ff @(posedge clk) begin
    if (prog_we_i) begin
      mem[prog_addr_i] <= prog_data_i;
    end
    if (accept) begin
      rd_data_q <= mem[rd_idx];
    end
  end

  rv_resp_fifo #(
    .WIDTH(RESP_W)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .s_tvalid(fifo_push),
    .s_tdata (infl_resp),
    .m_tvalid(fifo_out_valid),
    .m_tdata (fifo_out),
    .m_tready(fifo_pop),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_rv_imem_responder.sv
// tb/tb_rv_imem_responder.sv - randomized bench against a queue-based reference of the fetch responder
module tb_rv_imem_responder;

  localparam int          AW    = 64;
  localparam int          DL    = 6;
  localparam int          WORDS = 1 << DL;
  localparam logic [63:0] BASE  = 64'h100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [31:0]   resp_instr_o;
  logic [1:0]    resp_err_o;
  logic          flush_i;
  logic          prog_we_i;
  logic [DL-1:0] prog_addr_i;
  logic [31:0]   prog_data_i;
  logic          busy_o;

  always #5 clk = ~clk;

  rv_imem_responder #(
    .ADDR_WIDTH(AW),
    .DEPTH_LOG2(DL),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_instr_o(resp_instr_o),
    .resp_err_o  (resp_err_o),
    .flush_i     (flush_i),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .busy_o      (busy_o)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [WORDS];
  logic [33:0] exp_q [$];

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected {err, instr} straight from the address rules
  function automatic logic [33:0] ref_resp(input logic [63:0] addr);
    if (addr[1:0] != 2'b00) return {2'b01, NOP};
    if (addr < BASE) return {2'b10, NOP};
    if ((addr - BASE) >= 64'(4 * WORDS)) return {2'b10, NOP};
    return {2'b00, ref_mem[int'((addr - BASE) / 4)]};
  endfunction

  task automatic idle();
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    resp_ready_i = 1'b1;
    flush_i      = 1'b0;
    prog_we_i    = 1'b0;
    prog_addr_i  = '0;
    prog_data_i  = '0;
  endtask

  // Inputs are already driven; check outputs, advance one edge, update the model
  task automatic step();
    logic        exp_ready, exp_valid, pop, acc;
    logic [33:0] entry;
    #1;
    exp_ready = !rst && (exp_q.size() < 2) && !flush_i && !prog_we_i;
    exp_valid = (exp_q.size() != 0);
    expect_eq("req_ready", req_ready_o, exp_ready);
    expect_eq("resp_valid", resp_valid_o, exp_valid);
    expect_eq("busy", busy_o, exp_valid);
    if (exp_valid) begin
      expect_eq("instr", resp_instr_o, exp_q[0][31:0]);
      expect_eq("err", resp_err_o, exp_q[0][33:32]);
    end
    pop   = exp_valid && resp_ready_i;
    acc   = req_valid_i && exp_ready;
    entry = ref_resp(req_addr_i);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (flush_i) exp_q.delete();
      if (acc) exp_q.push_back(entry);
    end
    if (prog_we_i) ref_mem[prog_addr_i] = prog_data_i;
    #1;
  endtask

  task automatic request(input logic [63:0] addr, input logic rdy);
    idle();
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    resp_ready_i = rdy;
    step();
  endtask

  task automatic prog(input int idx, input logic [31:0] data);
    idle();
    prog_we_i   = 1'b1;
    prog_addr_i = DL'(idx);
    prog_data_i = data;
    step();
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return BASE + 64'(4 * $urandom_range(0, WORDS - 1));
    if (r == 6) return BASE + 64'(4 * $urandom_range(0, WORDS - 1)) + 64'($urandom_range(1, 3));
    if (r == 7) return BASE + 64'(4 * WORDS) + 64'(4 * $urandom_range(0, 7));
    if (r == 8) return 64'(4 * $urandom_range(0, 63));
    return {$urandom, $urandom};
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    idle();
    #1;
    expect_eq("reset_valid", resp_valid_o, 1'b0);
    expect_eq("reset_busy", busy_o, 1'b0);
    expect_eq("reset_err", resp_err_o, 2'b00);
    expect_eq("reset_instr", resp_instr_o, 32'h0);

    prog(0, 32'h0050_0093);
    prog(1, 32'h00A0_0113);
    for (int i = 2; i < WORDS; i++) prog(i, $urandom);

    // back-to-back fetches at full rate
    request(BASE, 1'b1);
    request(BASE + 64'h4, 1'b1);
    idle(); step(); step();

    // error codes and priority, including addresses near the top of the space
    request(BASE + 64'h6, 1'b1);
    request(BASE + 64'(4 * WORDS), 1'b1);
    request(BASE + 64'(4 * WORDS) + 64'h2, 1'b1);
    request(64'h0, 1'b1);
    request(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    request(BASE + 64'(4 * WORDS) - 64'h4, 1'b1);
    idle(); step(); step();

    // back-pressure: third request must be refused, buffered data held
    request(BASE + 64'h8, 1'b0);
    request(BASE + 64'h10, 1'b0);
    request(BASE + 64'h14, 1'b0);
    idle(); resp_ready_i = 1'b0; step(); step();
    idle(); step(); step(); step();

    // flush with two buffered
    request(BASE + 64'h18, 1'b0);
    request(BASE + 64'h1C, 1'b0);
    idle(); resp_ready_i = 1'b0; flush_i = 1'b1; step();
    idle(); step();
    request(BASE + 64'h4, 1'b1);
    idle(); step(); step();

    // write while the read of word 3 is in flight, then re-read
    request(BASE + 64'hC, 1'b0);
    prog(3, 32'hDEAD_BEEF);
    idle(); step(); step();
    request(BASE + 64'hC, 1'b1);
    idle(); step(); step();

    // reset with two buffered; program must survive
    request(BASE + 64'h0, 1'b0);
    request(BASE + 64'h4, 1'b0);
    idle(); resp_ready_i = 1'b0; rst = 1'b1; step();
    idle(); step();
    request(BASE + 64'h0, 1'b1);
    request(BASE + 64'hC, 1'b1);
    idle(); step(); step();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst          = ($urandom_range(0, 199) == 0);
      flush_i      = ($urandom_range(0, 19) == 0);
      prog_we_i    = ($urandom_range(0, 9) == 0);
      prog_addr_i  = DL'($urandom);
      prog_data_i  = $urandom;
      req_valid_i  = ($urandom_range(0, 9) < 7);
      req_addr_i   = rand_addr();
      resp_ready_i = ($urandom_range(0, 9) < 6);
      step();
    end
    idle(); step(); step(); step();
    expect_eq("final_busy", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
